// File: rtl/input_filter_16_pkg.sv
// Shared defaults for the input conditioning stage ahead of the DMA input scan.
package input_filter_16_pkg;

    localparam int N_IN_DEF    = 16;
    localparam int DEB_W_DEF   = 8;
    localparam int PRE_DIV_DEF = 1000;
    localparam int PRE_W_DEF   = 10;

endpackage

// File: rtl/input_filter_16_debounce_channel.sv
// One debounce channel: counts ticks while the synchronized input disagrees with
// the debounced state and commits the new level once DEB_LEN ticks have elapsed.
module debounce_channel
    import input_filter_16_pkg::*;
#(
    parameter int DEB_W = DEB_W_DEF
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             S,
    input  logic             TICK,
    input  logic [DEB_W-1:0] DEB_LEN,
    output logic             DB
);

    logic [DEB_W-1:0] cnt;
    logic [DEB_W:0]   cnt_inc;
    logic             bypass;
    logic             reached;

    assign bypass  = (DEB_LEN == '0);
    assign cnt_inc = {1'b0, cnt} + (DEB_W+1)'(1);
    // >= so a DEB_LEN lowered below the running count still commits on the next tick
    assign reached = (cnt_inc >= {1'b0, DEB_LEN});

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            cnt <= '0;
            DB  <= 1'b0;
        end else if (bypass) begin
            cnt <= '0;
            DB  <= S;
        end else if (S == DB) begin
            cnt <= '0;
        end else if (TICK) begin
            if (reached) begin
                cnt <= '0;
                DB  <= S;
            end else if (cnt != '1) begin
                cnt <= cnt_inc[DEB_W-1:0];
            end
        end
    end

endmodule

// File: rtl/input_filter_16.sv
// Synchronizes, debounces and freezes 16 field inputs for the DMA scan, and keeps
// sticky per-bit change flags until acknowledged.
module input_filter_16
    import input_filter_16_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int DEB_W   = DEB_W_DEF,
    parameter int PRE_DIV = PRE_DIV_DEF,
    parameter int PRE_W   = PRE_W_DEF
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [N_IN-1:0]  IN_RAW,
    input  logic [DEB_W-1:0] DEB_LEN,
    input  logic             FREEZE,
    input  logic             CHG_ACK,
    output logic [N_IN-1:0]  IN_F,
    output logic [N_IN-1:0]  CHG_MASK,
    output logic             CHG
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

    logic [N_IN-1:0]  sync_1;
    logic [N_IN-1:0]  sync_2;
    logic [N_IN-1:0]  db;
    logic [N_IN-1:0]  in_f_next;
    logic [N_IN-1:0]  chg_set;
    logic [N_IN-1:0]  mask_next;
    logic [PRE_W-1:0] pre_cnt;
    logic             started;
    logic             tick;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= IN_RAW;
            sync_2 <= sync_1;
        end
    end

    // started keeps PRE_DIV=1 from ticking in the first cycle out of reset
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            pre_cnt <= '0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    assign tick = started && (pre_cnt == PRE_LAST);

    for (genvar i = 0; i < N_IN; i++) begin : g_ch
        debounce_channel #(
            .DEB_W(DEB_W)
        ) u_ch (
            .CLK    (CLK),
            .CLR    (CLR),
            .S      (sync_2[i]),
            .TICK   (tick),
            .DEB_LEN(DEB_LEN),
            .DB     (db[i])
        );
    end

    assign in_f_next = FREEZE ? IN_F : db;
    assign chg_set   = in_f_next ^ IN_F;
    assign mask_next = chg_set | (CHG_ACK ? '0 : CHG_MASK);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            IN_F     <= '0;
            CHG_MASK <= '0;
            CHG      <= 1'b0;
        end else begin
            IN_F     <= in_f_next;
            CHG_MASK <= mask_next;
            CHG      <= |mask_next;
        end
    end

endmodule
